// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the 32x32 register file: the pipeline WB stage has priority,
// MDU results queue in a small FIFO, with an in-flight scoreboard and a starvation request.
module regfile_wb_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PIPE_WE,
    input  logic [4:0]  PIPE_ADDR,
    input  logic [31:0] PIPE_DATA,
    input  logic        MDU_VALID,
    input  logic [4:0]  MDU_ADDR,
    input  logic [31:0] MDU_DATA,
    output logic        MDU_READY,
    input  logic        ISSUE,
    input  logic [4:0]  ISSUE_ADDR,
    output logic        RF_WRITE,
    output logic [4:0]  RF_INADDRESS,
    output logic [31:0] RF_IN,
    output logic [31:0] PENDING,
    output logic        STARVE
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

    logic [4:0]       fifo_addr [DEPTH];
    logic [31:0]      fifo_data [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_next;
    logic [31:0]      pending_next;
    logic             pipe_req;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic [4:0]       head_addr;
    logic [31:0]      head_data;

    assign MDU_READY  = (count < FULL_CNT);
    assign fifo_empty = (count == '0);
    // A write to x0 is no request at all, so it leaves the slot to the FIFO.
    assign pipe_req   = PIPE_WE && (PIPE_ADDR != 5'd0);
    // Results for x0 complete the handshake but are dropped here.
    assign push       = MDU_VALID && MDU_READY && (MDU_ADDR != 5'd0);
    assign pop        = !pipe_req && !fifo_empty;
    assign head_addr  = fifo_addr[rd_ptr];
    assign head_data  = fifo_data[rd_ptr];

    always_comb begin
        wait_cnt_next = '0;
        if (!fifo_empty && !pop) begin
            wait_cnt_next = (wait_cnt == WAIT_LIM) ? wait_cnt : wait_cnt + CNT_W'(1);
        end
    end

    // Issue is applied after the pop clear so a same-edge set wins.
    always_comb begin
        pending_next = PENDING;
        if (pop) begin
            pending_next[head_addr] = 1'b0;
        end
        if (ISSUE && (ISSUE_ADDR != 5'd0)) begin
            pending_next[ISSUE_ADDR] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_addr[wr_ptr] <= MDU_ADDR;
            fifo_data[wr_ptr] <= MDU_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            wait_cnt     <= '0;
            STARVE       <= 1'b0;
            PENDING      <= '0;
            RF_WRITE     <= 1'b0;
            RF_INADDRESS <= '0;
            RF_IN        <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
            wait_cnt <= wait_cnt_next;
            STARVE   <= (wait_cnt_next == WAIT_LIM);
            PENDING  <= pending_next;
            if (pipe_req) begin
                RF_WRITE     <= 1'b1;
                RF_INADDRESS <= PIPE_ADDR;
                RF_IN        <= PIPE_DATA;
            end else if (pop) begin
                RF_WRITE     <= 1'b1;
                RF_INADDRESS <= head_addr;
                RF_IN        <= head_data;
            end else begin
                RF_WRITE <= 1'b0;
            end
        end
    end

endmodule
